mux_rr_arbiter: RTL and testbench

// Registered N-channel, n-bit arbitrating multiplexer with valid/ready handshakes.

---
 rtl/mux_rr_arbiter.sv | 99 +++++++++
 tb/tb_mux_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: registered N-channel arbitrating multiplexer.
// Picks one requester per cycle, either round-robin or by a forced index,
// and holds the chosen word in a single output register with valid/ready.
module mux_rr_arbiter #(
    parameter int n  = 32,
    parameter int ch = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ch-1:0]          inValid,
    input  logic [ch*n-1:0]        inData,
    output logic [ch-1:0]          inReady,
    input  logic                   forceEn,
    input  logic [$clog2(ch)-1:0]  forceSel,
    output logic                   outValid,
    output logic [n-1:0]           outData,
    output logic [$clog2(ch)-1:0]  outChan,
    input  logic                   outReady
);

    localparam int sw = $clog2(ch);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } regState_t;

    regState_t        state;
    regState_t        nextState;
    logic             load;
    logic             anyGrant;
    logic [ch-1:0]    grant;
    logic [sw-1:0]    sel;
    logic [sw-1:0]    scanIdx;
    logic [sw-1:0]    rrPtr;

    // The register can take a new word when it is empty or being drained this cycle
    assign load     = (state == EMPTY) | outReady;
    assign anyGrant = |grant;
    assign inReady  = grant & {ch{load}};
    assign outValid = (state == FULL);

    // Grant selection: forced index in mux mode, otherwise scan from rrPtr+1 so
    // the most recently served channel is considered last. The loop walks from
    // the furthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        grant   = '0;
        sel     = '0;
        scanIdx = '0;
        if (forceEn) begin
            if ((int'(forceSel) < ch) && inValid[forceSel]) begin
                grant[forceSel] = 1'b1;
                sel             = forceSel;
            end
        end else begin
            for (int k = ch; k >= 1; k--) begin
                scanIdx = sw'((int'(rrPtr) + k) % ch);
                if (inValid[scanIdx]) begin
                    grant          = '0;
                    grant[scanIdx] = 1'b1;
                    sel            = scanIdx;
                end
            end
        end
    end

    // Output register occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Next occupancy: refill when granted, empty when drained with nothing granted
    always_comb begin
        nextState = state;
        if (load) begin
            nextState = anyGrant ? FULL : EMPTY;
        end
    end

    // Datapath and pointer: capture the winner; forced transfers leave rrPtr alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outData <= '0;
            outChan <= '0;
            rrPtr   <= sw'(ch - 1);
        end else if (load && anyGrant) begin
            outData <= inData[int'(sel)*n +: n];
            outChan <= sel;
            if (!forceEn) begin
                rrPtr <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed self-checking bench for mux_rr_arbiter (ch=4, n=32).
module tb_mux_rr_arbiter;

    localparam int N  = 32;
    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     inValid;
    logic [CH*N-1:0]   inData;
    logic [CH-1:0]     inReady;
    logic              forceEn;
    logic [1:0]        forceSel;
    logic              outValid;
    logic [N-1:0]      outData;
    logic [1:0]        outChan;
    logic              outReady;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.n(N), .ch(CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inData   (inData),
        .inReady  (inReady),
        .forceEn  (forceEn),
        .forceSel (forceSel),
        .outValid (outValid),
        .outData  (outData),
        .outChan  (outChan),
        .outReady (outReady)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i carries base + i
    task automatic setData(input logic [31:0] base);
        for (int i = 0; i < CH; i++) begin
            inData[i*N +: N] = base + 32'(i);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        inValid  = '0;
        outReady = 1'b0;
        forceEn  = 1'b0;
        forceSel = '0;
        setData(32'hA000_0000);
        rst      = 1'b1;
        #12;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", outValid); end
        checks++; if (outData !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h expected 00000000", outData); end
        checks++; if (outChan !== 2'd0) begin errors++; $display("[TB] FAIL reset_chan got %0d expected 0", outChan); end
        // Load a word, then hit reset while it is held
        @(posedge clk);
        #1;
        rst     = 1'b0;
        inValid = 4'b0100;
        tick();
        checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid got %b expected 1", outValid); end
        checks++; if (outChan !== 2'd2) begin errors++; $display("[TB] FAIL pre_reset_chan got %0d expected 2", outChan); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid got %b expected 0", outValid); end
        checks++; if (outData !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_data got %h expected 00000000", outData); end
        checks++; if (outChan !== 2'd0) begin errors++; $display("[TB] FAIL async_reset_chan got %0d expected 0", outChan); end
        tick();
        rst      = 1'b0;
        inValid  = 4'b1111;
        outReady = 1'b1;
        #1;
        checks++; if (inReady !== 4'b0001) begin errors++; $display("[TB] FAIL post_reset_ready got %b expected 0001", inReady); end
        tick();
        checks++; if (outChan !== 2'd0) begin errors++; $display("[TB] FAIL post_reset_chan got %0d expected 0", outChan); end
        checks++; if (outData !== 32'hA000_0000) begin errors++; $display("[TB] FAIL post_reset_data got %h expected a0000000", outData); end
        checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_valid got %b expected 1", outValid); end
    endtask

    task automatic test_round_robin();
        inValid = '0;
        doReset();
        setData(32'hB000_0000);
        inValid  = 4'b1111;
        outReady = 1'b1;
        forceEn  = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rr_start_valid got %b expected 0", outValid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid[%0d] got %b expected 1", i, outValid); end
            checks++; if (outChan !== 2'(i % 4)) begin errors++; $display("[TB] FAIL rr_chan[%0d] got %0d expected %0d", i, outChan, i % 4); end
            checks++; if (outData !== 32'hB000_0000 + 32'(i % 4)) begin errors++; $display("[TB] FAIL rr_data[%0d] got %h expected %h", i, outData, 32'hB000_0000 + 32'(i % 4)); end
        end
    endtask

    task automatic test_back_pressure();
        outReady = 1'b0;
        setData(32'hC000_0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (inReady !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b expected 0000", i, inReady); end
            tick();
            checks++; if (outChan !== 2'd0) begin errors++; $display("[TB] FAIL bp_chan[%0d] got %0d expected 0", i, outChan); end
            checks++; if (outData !== 32'hB000_0000) begin errors++; $display("[TB] FAIL bp_data[%0d] got %h expected b0000000", i, outData); end
            checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d] got %b expected 1", i, outValid); end
        end
        outReady = 1'b1;
        #1;
        checks++; if (inReady !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release_ready got %b expected 0010", inReady); end
        tick();
        checks++; if (outChan !== 2'd1) begin errors++; $display("[TB] FAIL bp_release_chan got %0d expected 1", outChan); end
        checks++; if (outData !== 32'hC000_0001) begin errors++; $display("[TB] FAIL bp_release_data got %h expected c0000001", outData); end
    endtask

    task automatic test_wrap_skip();
        inValid = 4'b0100;
        tick();
        checks++; if (outChan !== 2'd2) begin errors++; $display("[TB] FAIL wrap_setup_chan got %0d expected 2", outChan); end
        inValid = 4'b0011;
        #1;
        checks++; if (inReady !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_ready got %b expected 0001", inReady); end
        tick();
        checks++; if (outChan !== 2'd0) begin errors++; $display("[TB] FAIL wrap_chan0 got %0d expected 0", outChan); end
        checks++; if (outData !== 32'hC000_0000) begin errors++; $display("[TB] FAIL wrap_data0 got %h expected c0000000", outData); end
        tick();
        checks++; if (outChan !== 2'd1) begin errors++; $display("[TB] FAIL wrap_chan1 got %0d expected 1", outChan); end
        checks++; if (outData !== 32'hC000_0001) begin errors++; $display("[TB] FAIL wrap_data1 got %h expected c0000001", outData); end
    endtask

    task automatic test_mux_mode();
        forceEn  = 1'b1;
        forceSel = 2'd2;
        inValid  = 4'b1111;
        setData(32'hD000_0000);
        inData[2*N +: N] = 32'hDEAD_BEEF;
        #1;
        checks++; if (inReady !== 4'b0100) begin errors++; $display("[TB] FAIL mux_ready got %b expected 0100", inReady); end
        tick();
        checks++; if (outData !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mux_data got %h expected deadbeef", outData); end
        checks++; if (outChan !== 2'd2) begin errors++; $display("[TB] FAIL mux_chan got %0d expected 2", outChan); end
        checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL mux_valid got %b expected 1", outValid); end
        inValid = 4'b1011;
        #1;
        checks++; if (inReady !== 4'b0000) begin errors++; $display("[TB] FAIL mux_nogrant_ready got %b expected 0000", inReady); end
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL mux_nogrant_valid got %b expected 0", outValid); end
        checks++; if (outData !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mux_nogrant_data got %h expected deadbeef", outData); end
        // Pointer was left at 1 by the last round-robin grant, so the scan starts at 2
        forceEn = 1'b0;
        inValid = 4'b1111;
        setData(32'hE000_0000);
        tick();
        checks++; if (outChan !== 2'd2) begin errors++; $display("[TB] FAIL mux_ptr_kept_chan got %0d expected 2", outChan); end
        checks++; if (outData !== 32'hE000_0002) begin errors++; $display("[TB] FAIL mux_ptr_kept_data got %h expected e0000002", outData); end
    endtask

    task automatic test_idle();
        inValid  = '0;
        outReady = 1'b1;
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid got %b expected 0", outValid); end
        checks++; if (outData !== 32'hE000_0002) begin errors++; $display("[TB] FAIL idle_data got %h expected e0000002", outData); end
        checks++; if (outChan !== 2'd2) begin errors++; $display("[TB] FAIL idle_chan got %0d expected 2", outChan); end
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid2 got %b expected 0", outValid); end
    endtask

    // Scenario sequence; each task leaves the DUT in the state the next one expects
    initial begin
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_wrap_skip();
        test_mux_mode();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
